// File: rtl/serpent_icache.sv
// serpent_icache: 4-way set-associative instruction cache with TLB port, non-cacheable bypass and memory refill.
module serpent_icache #(
  parameter logic [63:0] CachedAddrBeg = 64'h0,
  parameter logic [63:0] CachedAddrEnd = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned Sets = 64,
  localparam int unsigned IW = $clog2(Sets)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          en_i,
  output logic          miss_o,
  input  logic          dreq_req_i,
  input  logic          dreq_kill_s1_i,
  input  logic          dreq_kill_s2_i,
  input  logic [63:0]   dreq_vaddr_i,
  output logic          dreq_ready_o,
  output logic          dreq_valid_o,
  output logic [31:0]   dreq_data_o,
  output logic [63:0]   dreq_vaddr_o,
  output logic          dreq_ex_o,
  output logic          areq_req_o,
  output logic [63:0]   areq_vaddr_o,
  input  logic          areq_valid_i,
  input  logic [63:0]   areq_paddr_i,
  input  logic          areq_ex_i,
  output logic          mem_data_req_o,
  output logic [63:0]   mem_data_paddr_o,
  output logic          mem_data_nc_o,
  input  logic          mem_data_ack_i,
  input  logic          mem_rtrn_vld_i,
  input  logic          mem_rtrn_inv_i,
  input  logic [127:0]  mem_rtrn_data_i,
  input  logic          mem_rtrn_inv_all_i,
  input  logic [IW-1:0] mem_rtrn_inv_idx_i,
  input  logic [1:0]    mem_rtrn_inv_way_i
);
  localparam int unsigned TW = 60 - IW;

  typedef enum logic [2:0] {FLUSH, IDLE, READ, MISS, KILL_MISS} state_e;

  state_e state_q, state_d;
  logic [Sets-1:0] valid_q [4];
  logic [TW-1:0] tag_q [4][Sets];
  logic [127:0] data_q [4][Sets];
  logic [IW-1:0] cnt_q, idx;
  logic [63:0] vaddr_q, paddr_q;
  logic nc_q, mem_req_q, miss_q, flush_pend_q;
  logic [1:0] rr_q, repl;
  logic [3:0] hit;
  logic [127:0] hit_line;
  logic start, rtrn_inv, rtrn_fill, cacheable, kill_any, fill_we, go_miss;

  function automatic logic le64(input logic [63:0] a, input logic [63:0] b);
    return a <= b;
  endfunction

  assign idx = vaddr_q[IW+3:4];
  assign rtrn_inv = mem_rtrn_vld_i & mem_rtrn_inv_i;
  assign rtrn_fill = mem_rtrn_vld_i & ~mem_rtrn_inv_i;
  assign kill_any = dreq_kill_s2_i | flush_i;
  assign cacheable = en_i & le64(CachedAddrBeg, areq_paddr_i) & le64(areq_paddr_i, CachedAddrEnd);
  assign dreq_ready_o = (state_q == IDLE) & ~flush_i;
  assign start = dreq_ready_o & dreq_req_i & ~dreq_kill_s1_i;
  assign areq_req_o = (state_q == READ) | start;
  assign areq_vaddr_o = (state_q == READ) ? vaddr_q : start ? dreq_vaddr_i : '0;
  assign dreq_vaddr_o = vaddr_q;
  assign miss_o = miss_q;
  assign mem_data_req_o = mem_req_q;
  assign mem_data_nc_o = nc_q;
  assign mem_data_paddr_o = nc_q ? {paddr_q[63:2], 2'b00} : {paddr_q[63:4], 4'b0000};

  // A same-cycle invalidation of the line being looked up masks its hit.
  always_comb begin
    hit = '0;
    hit_line = '0;
    repl = rr_q;
    for (int w = 3; w >= 0; w--) begin
      hit[w] = valid_q[w][idx] & (tag_q[w][idx] == areq_paddr_i[63:IW+4])
             & ~(rtrn_inv & (mem_rtrn_inv_all_i | (mem_rtrn_inv_idx_i == idx && mem_rtrn_inv_way_i == 2'(w))));
      hit_line = hit_line | ({128{hit[w]}} & data_q[w][idx]);
      if (!valid_q[w][idx]) repl = 2'(w);
    end
  end

  always_comb begin
    state_d = state_q;
    dreq_valid_o = 1'b0;
    dreq_ex_o = 1'b0;
    dreq_data_o = '0;
    fill_we = 1'b0;
    go_miss = 1'b0;
    unique case (state_q)
      FLUSH: state_d = (cnt_q == IW'(Sets - 1)) ? IDLE : FLUSH;
      IDLE: state_d = flush_i ? FLUSH : start ? READ : IDLE;
      READ: begin
        if (flush_i) state_d = FLUSH;
        else if (dreq_kill_s2_i) state_d = IDLE;
        else if (areq_valid_i) begin
          dreq_valid_o = areq_ex_i | (cacheable & |hit);
          dreq_ex_o = areq_ex_i;
          dreq_data_o = areq_ex_i ? '0 : hit_line[32*areq_paddr_i[3:2] +: 32];
          go_miss = ~dreq_valid_o;
          state_d = go_miss ? MISS : IDLE;
        end
      end
      MISS: begin
        if (rtrn_fill) begin
          fill_we = ~nc_q;
          dreq_valid_o = ~kill_any;
          dreq_data_o = kill_any ? '0 : mem_rtrn_data_i[32*paddr_q[3:2] +: 32];
          state_d = flush_i ? FLUSH : IDLE;
        end else if (kill_any) state_d = KILL_MISS;
      end
      KILL_MISS: begin
        fill_we = rtrn_fill & ~nc_q;
        state_d = ~rtrn_fill ? KILL_MISS : (flush_pend_q | flush_i) ? FLUSH : IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FLUSH;
      cnt_q <= '0;
      vaddr_q <= '0;
      paddr_q <= '0;
      nc_q <= 1'b0;
      mem_req_q <= 1'b0;
      miss_q <= 1'b0;
      flush_pend_q <= 1'b0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= (state_q == FLUSH && state_d == FLUSH) ? cnt_q + 1'b1 : '0;
      miss_q <= go_miss;
      flush_pend_q <= (state_q == MISS) ? flush_i : (state_q == KILL_MISS) ? (flush_pend_q | flush_i) : 1'b0;
      if (start) vaddr_q <= dreq_vaddr_i;
      if (go_miss) begin
        paddr_q <= areq_paddr_i;
        nc_q <= ~cacheable;
        mem_req_q <= 1'b1;
      end else if (mem_data_ack_i) mem_req_q <= 1'b0;
      if (fill_we) rr_q <= rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < 4; w++) begin
      if (rst_i) valid_q[w] <= '0;
      else begin
        if (state_q == FLUSH) valid_q[w][cnt_q] <= 1'b0;
        if (fill_we && repl == 2'(w)) valid_q[w][idx] <= 1'b1;
        if (rtrn_inv && mem_rtrn_inv_all_i) valid_q[w] <= '0;
        else if (rtrn_inv && mem_rtrn_inv_way_i == 2'(w)) valid_q[w][mem_rtrn_inv_idx_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < 4; w++) begin
      if (fill_we && repl == 2'(w)) begin
        tag_q[w][idx] <= paddr_q[63:IW+4];
        data_q[w][idx] <= mem_rtrn_data_i;
      end
    end
  end
endmodule

// File: tb/tb_serpent_icache.sv
// tb_serpent_icache: randomized scoreboard bench for serpent_icache against a set/way cache model.
module tb_serpent_icache;
  logic clk_i = 1'b0;
  logic rst_i, flush_i, en_i, miss_o;
  logic dreq_req_i, dreq_kill_s1_i, dreq_kill_s2_i, dreq_ready_o, dreq_valid_o, dreq_ex_o;
  logic [63:0] dreq_vaddr_i, dreq_vaddr_o;
  logic [31:0] dreq_data_o;
  logic areq_req_o, areq_valid_i, areq_ex_i;
  logic [63:0] areq_vaddr_o, areq_paddr_i;
  logic mem_data_req_o, mem_data_nc_o, mem_data_ack_i;
  logic [63:0] mem_data_paddr_o;
  logic mem_rtrn_vld_i, mem_rtrn_inv_i, mem_rtrn_inv_all_i;
  logic [127:0] mem_rtrn_data_i;
  logic [5:0] mem_rtrn_inv_idx_i;
  logic [1:0] mem_rtrn_inv_way_i;

  serpent_icache dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .en_i(en_i), .miss_o(miss_o),
    .dreq_req_i(dreq_req_i), .dreq_kill_s1_i(dreq_kill_s1_i), .dreq_kill_s2_i(dreq_kill_s2_i),
    .dreq_vaddr_i(dreq_vaddr_i), .dreq_ready_o(dreq_ready_o), .dreq_valid_o(dreq_valid_o),
    .dreq_data_o(dreq_data_o), .dreq_vaddr_o(dreq_vaddr_o), .dreq_ex_o(dreq_ex_o),
    .areq_req_o(areq_req_o), .areq_vaddr_o(areq_vaddr_o), .areq_valid_i(areq_valid_i),
    .areq_paddr_i(areq_paddr_i), .areq_ex_i(areq_ex_i), .mem_data_req_o(mem_data_req_o),
    .mem_data_paddr_o(mem_data_paddr_o), .mem_data_nc_o(mem_data_nc_o), .mem_data_ack_i(mem_data_ack_i),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_inv_i(mem_rtrn_inv_i), .mem_rtrn_data_i(mem_rtrn_data_i),
    .mem_rtrn_inv_all_i(mem_rtrn_inv_all_i), .mem_rtrn_inv_idx_i(mem_rtrn_inv_idx_i),
    .mem_rtrn_inv_way_i(mem_rtrn_inv_way_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [63:0] va;
    logic        ex;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0, fails = 0;
  logic [31:0] cyc = 0;

  bit m_valid [4][64];
  logic [53:0] m_tag [4][64];
  logic [127:0] m_data [4][64];
  int m_rr;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && dreq_valid_o) begin
      if (sb.size() == 0) chk(1'b0, "unexpected_resp", {dreq_data_o, dreq_vaddr_o}, 0);
      else begin
        e = sb.pop_front();
        chk({dreq_data_o, dreq_vaddr_o, dreq_ex_o, cyc} == e, "resp", {dreq_data_o, dreq_vaddr_o, dreq_ex_o, cyc}, e);
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear;
    for (int w = 0; w < 4; w++) for (int s = 0; s < 64; s++) m_valid[w][s] = 0;
  endtask

  function automatic bit model_lookup(input logic [63:0] va, input logic [63:0] pa, output logic [31:0] word);
    int s = int'(va[9:4]);
    word = 0;
    for (int w = 0; w < 4; w++)
      if (m_valid[w][s] && m_tag[w][s] == pa[63:10]) begin
        word = m_data[w][s][32*pa[3:2] +: 32];
        return 1;
      end
    return 0;
  endfunction

  task automatic model_fill(input logic [63:0] va, input logic [63:0] pa, input logic [127:0] line);
    int s = int'(va[9:4]);
    int way = -1;
    for (int w = 0; w < 4; w++) if (way < 0 && !m_valid[w][s]) way = w;
    if (way < 0) way = m_rr;
    m_rr = (m_rr + 1) % 4;
    m_valid[way][s] = 1;
    m_tag[way][s] = pa[63:10];
    m_data[way][s] = line;
  endtask

  task automatic drive_idle;
    flush_i = 0; dreq_req_i = 0; dreq_kill_s1_i = 0; dreq_kill_s2_i = 0;
    areq_valid_i = 0; areq_ex_i = 0; mem_data_ack_i = 0; mem_rtrn_vld_i = 0;
    mem_rtrn_inv_i = 0; mem_rtrn_inv_all_i = 0;
  endtask

  task automatic do_reset;
    int zeros = 0;
    rst_i = 1; drive_idle(); en_i = 1; dreq_vaddr_i = 0; areq_paddr_i = 0;
    mem_rtrn_data_i = 0; mem_rtrn_inv_idx_i = 0; mem_rtrn_inv_way_i = 0;
    repeat (3) tick();
    chk({dreq_ready_o, dreq_valid_o, miss_o, mem_data_req_o, areq_req_o} == 0, "reset_outputs",
        {dreq_ready_o, dreq_valid_o, miss_o, mem_data_req_o, areq_req_o}, 0);
    rst_i = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (!dreq_ready_o) zeros++;
      @(posedge clk_i);
    end
    @(negedge clk_i);
    chk(zeros == 64, "flush_ready_low", zeros, 64);
    chk(dreq_ready_o, "ready_after_flush", dreq_ready_o, 1);
    model_clear();
    m_rr = 0;
    tick();
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!dreq_ready_o && n < 300) begin
      tick();
      n++;
    end
    if (!dreq_ready_o) chk(1'b0, "ready_timeout", 0, 1);
  endtask

  task automatic send_inv(input bit all, input logic [5:0] s, input logic [1:0] w);
    mem_rtrn_vld_i = 1; mem_rtrn_inv_i = 1; mem_rtrn_inv_all_i = all;
    mem_rtrn_inv_idx_i = s; mem_rtrn_inv_way_i = w;
    if (all) model_clear(); else m_valid[w][s] = 0;
    tick();
    mem_rtrn_vld_i = 0; mem_rtrn_inv_i = 0; mem_rtrn_inv_all_i = 0;
  endtask

  // kill: 0 none, 1 kill_s2 during translation, 2 kill_s2 during refill, 3 flush during refill
  task automatic fetch(input logic [63:0] va, input logic [63:0] pa, input bit en, input bit ex,
                       input logic [127:0] line, input int kill, input bit inv_now, input int lat);
    logic [31:0] word;
    logic [63:0] exp_pa;
    bit hold_ok = 1;
    wait_ready();
    dreq_req_i = 1; dreq_vaddr_i = va; en_i = en;
    tick();
    dreq_req_i = 0;
    chk(areq_req_o && areq_vaddr_o == va, "areq", {areq_req_o, areq_vaddr_o}, {1'b1, va});
    repeat (lat) tick();
    if (kill == 1) begin
      dreq_kill_s2_i = 1;
      tick();
      dreq_kill_s2_i = 0;
      return;
    end
    areq_valid_i = 1; areq_paddr_i = pa; areq_ex_i = ex;
    if (inv_now) begin
      mem_rtrn_vld_i = 1; mem_rtrn_inv_i = 1; mem_rtrn_inv_all_i = 1;
      model_clear();
    end
    if (ex) begin
      sb.push_back({32'h0, va, 1'b1, cyc});
      tick();
      drive_idle();
      chk(!mem_data_req_o, "ex_no_mem", mem_data_req_o, 0);
      return;
    end
    if (en && model_lookup(va, pa, word)) begin
      sb.push_back({word, va, 1'b0, cyc});
      tick();
      drive_idle();
      return;
    end
    tick();
    drive_idle();
    exp_pa = en ? {pa[63:4], 4'h0} : {pa[63:2], 2'b00};
    chk(mem_data_req_o && miss_o && mem_data_paddr_o == exp_pa && mem_data_nc_o == !en, "miss_req",
        {mem_data_req_o, miss_o, mem_data_nc_o, mem_data_paddr_o}, {2'b11, !en, exp_pa});
    repeat ($urandom_range(0, 2)) begin
      tick();
      if (!(mem_data_req_o && mem_data_paddr_o == exp_pa)) hold_ok = 0;
    end
    chk(hold_ok, "req_hold", hold_ok, 1);
    mem_data_ack_i = 1;
    tick();
    mem_data_ack_i = 0;
    chk(!mem_data_req_o, "req_drop", mem_data_req_o, 0);
    repeat ($urandom_range(0, 2)) tick();
    if (kill >= 2) begin
      if (kill == 2) dreq_kill_s2_i = 1; else flush_i = 1;
      tick();
      dreq_kill_s2_i = 0; flush_i = 0;
      repeat ($urandom_range(0, 2)) tick();
    end
    mem_rtrn_vld_i = 1; mem_rtrn_inv_i = 0; mem_rtrn_data_i = line;
    if (kill == 0) sb.push_back({line[32*pa[3:2] +: 32], va, 1'b0, cyc});
    if (en) model_fill(va, pa, line);
    if (kill == 3) model_clear();
    tick();
    mem_rtrn_vld_i = 0;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] l1 = {32'd4, 32'd3, 32'd2, 32'd1};
    logic [127:0] l2 = {32'd8, 32'd7, 32'd6, 32'd5};
    logic [63:0] va;
    do_reset();
    fetch(64'h2000, 64'h2000, 1, 0, l1, 0, 0, 0);
    fetch(64'h2004, 64'h2004, 1, 0, l1, 0, 0, 0);
    fetch(64'h2004, 64'h2004, 0, 0, l2, 0, 0, 1);
    fetch(64'h2000, 64'h2000, 1, 0, l2, 0, 0, 0);
    fetch(64'h3000, 64'h3000, 1, 0, rand_line(), 2, 0, 1);
    fetch(64'h3008, 64'h3008, 1, 0, rand_line(), 0, 0, 0);
    do_reset();
    for (int k = 1; k <= 5; k++) fetch(64'h50 | (64'(k) << 10), 64'h50 | (64'(k) << 10), 1, 0, rand_line(), 0, 0, 0);
    for (int k = 2; k <= 5; k++) fetch(64'h54 | (64'(k) << 10), 64'h54 | (64'(k) << 10), 1, 0, rand_line(), 0, 0, 0);
    fetch(64'h458, 64'h458, 1, 0, rand_line(), 0, 0, 0);
    send_inv(1, 0, 0);
    for (int k = 2; k <= 5; k++) fetch(64'h5C | (64'(k) << 10), 64'h5C | (64'(k) << 10), 1, 0, rand_line(), 0, 0, 1);
    fetch(64'h5000, 64'h5000, 1, 1, rand_line(), 0, 0, 0);
    for (int t = 0; t < 400; t++) begin
      int r = $urandom_range(0, 99);
      int k = $urandom_range(0, 99);
      int kill = (k < 5) ? 1 : (k < 13) ? 2 : (k < 15) ? 3 : 0;
      if (r < 8) send_inv(0, 6'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
      else if (r < 10) send_inv(1, 0, 0);
      else if (r < 12) begin
        wait_ready();
        flush_i = 1; dreq_req_i = 1; dreq_vaddr_i = 64'h8000_0000;
        model_clear();
        tick();
        flush_i = 0; dreq_req_i = 0;
      end else if (r < 15) begin
        wait_ready();
        dreq_req_i = 1; dreq_kill_s1_i = 1;
        tick();
        dreq_req_i = 0; dreq_kill_s1_i = 0;
        chk(!areq_req_o, "kill_s1_drop", areq_req_o, 0);
      end
      va = 64'h8000_0000 | (64'($urandom_range(0, 5)) << 10) | (64'($urandom_range(0, 2)) << 4) | (64'($urandom_range(0, 3)) << 2);
      fetch(va, va ^ 64'h1_0000_0000, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 5,
            rand_line(), kill, $urandom_range(0, 99) < 3, $urandom_range(0, 2));
    end
    repeat (4) tick();
    chk(sb.size() == 0, "drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/serpent_icache.md
# serpent_icache

Instruction cache between the fetch frontend and the L1.5/memory interface: 32-bit fetches by virtual address, translated through an external TLB port, served from a 4-way set-associative cache of 16-byte lines. Addresses outside the cacheable window, or any access while the cache is disabled, bypass the arrays as single non-cacheable reads.

## Interface
- CachedAddrBeg, 64'h0: lowest cacheable physical address (inclusive).
- CachedAddrEnd, 64'hFFFF_FFFF_FFFF_FFFF: highest cacheable physical address (inclusive).
- Sets, 64: sets per way. Each way is Sets×16 B; index = vaddr[log2(Sets)+3:4].
- clk_i in 1: clock.
- rst_i in 1: reset, synchronous and active-high.
- flush_i in 1: invalidate all lines and abort the in-flight request.
- en_i in 1: cache enable. When 0, every access is non-cacheable.
- miss_o out 1: 1-cycle pulse when a memory request is issued.
- dreq_req_i / dreq_kill_s1_i / dreq_kill_s2_i in 1: fetch request, kill of the request being accepted, kill of the request in flight.
- dreq_vaddr_i in 64: fetch address, 4-byte aligned.
- dreq_ready_o out 1: request accepted when dreq_req_i & dreq_ready_o.
- dreq_valid_o out 1: response strobe. Response fields: dreq_data_o (32), dreq_vaddr_o (64), dreq_ex_o (1).
- areq_req_o out 1, areq_vaddr_o out 64: translation request.
- areq_valid_i in 1, areq_paddr_i in 64, areq_ex_i in 1: translation result.
- mem_data_req_o out 1, mem_data_paddr_o out 64, mem_data_nc_o out 1: refill request, held until mem_data_ack_i (in 1).
- mem_rtrn_vld_i in 1, mem_rtrn_inv_i in 1 (0 = fill, 1 = invalidate), mem_rtrn_data_i in 128: memory return.
- mem_rtrn_inv_all_i in 1, mem_rtrn_inv_idx_i in log2(Sets), mem_rtrn_inv_way_i in 2: invalidation target.

## Operation
- Per way: valid bit, tag paddr[63:log2(Sets)+4], 128-bit data line.
- States: FLUSH, IDLE, READ, MISS, KILL_MISS.
- FLUSH:
  - Entered on reset and on flush_i from IDLE/READ.
  - Clears one set per cycle over Sets cycles, then goes to IDLE.
  - dreq_ready_o = 0 throughout.
- IDLE:
  - dreq_ready_o = 1.
  - On accept with dreq_kill_s1_i = 0: capture vaddr, read the set, assert areq_req_o/areq_vaddr_o, go to READ.
  - On accept with dreq_kill_s1_i = 1: the request is dropped.
- READ: wait for areq_valid_i (areq_req_o stays high). Then:
  - areq_ex_i: dreq_valid_o with dreq_ex_o = 1, data 0; go to IDLE.
  - cacheable = en_i & CachedAddrBeg ≤ paddr ≤ CachedAddrEnd.
  - Cacheable hit (valid & tag match, at most one way): dreq_valid_o, data = line word paddr[3:2], dreq_vaddr_o = captured vaddr; go to IDLE.
  - Miss or non-cacheable: pulse miss_o, raise mem_data_req_o, go to MISS.
    - Cacheable: mem_data_paddr_o = line-aligned paddr, mem_data_nc_o = 0.
    - Non-cacheable: mem_data_paddr_o = word-aligned paddr, mem_data_nc_o = 1.
- MISS:
  - Drop mem_data_req_o after the ack cycle.
  - On a fill return:
    - dreq_valid_o with word paddr[3:2] of the returned line.
    - If cacheable, write the line into the replacement way: lowest invalid way, else a 2-bit round-robin counter (advanced on every fill).
    - Go to IDLE.
- Kill / flush in flight:
  - dreq_kill_s2_i in READ returns to IDLE with no response.
  - dreq_kill_s2_i or flush_i in MISS goes to KILL_MISS.
  - KILL_MISS waits for the fill, writes it if cacheable, emits no response, then goes to IDLE (or FLUSH if flush_i was the cause).
  - A killed request never produces dreq_valid_o.
- Invalidation return:
  - Clears the valid bit of (idx, way), or all valid bits if mem_rtrn_inv_all_i.
  - Accepted in any state.
  - A hit in the same cycle on the invalidated line is treated as a miss.
- One request in flight at most. Responses are in order.

## Timing
- Reset: all outputs 0; state FLUSH for Sets cycles after rst_i deasserts.
- Array read is registered. The earliest response is the cycle after accept, when areq_valid_i = 1 in that cycle (hit latency 1).
- Miss response is combinational in the mem_rtrn_vld_i cycle. IDLE is re-entered the next cycle.
- mem_data_req_o rises the cycle after translation and holds, with stable address, until ack (ack may arrive in the same cycle).
- flush_i has priority over a new request in the same cycle: no accept.

## Test plan
- Reset, then 64 cycles with dreq_ready_o = 0; ready rises on cycle 65.
- en_i = 1, paddr 0x2000 cold miss:
  - Expect miss_o, request paddr 0x2000 with nc = 0.
  - Fill 128'h4_3_2_1 (words) returns data 1.
  - Re-read vaddr +4 hits with data 2 one cycle after accept.
- en_i = 0 read of the same address: nc = 1, paddr 0x2004, no array update, hit never occurs.
- dreq_kill_s2_i during MISS: fill accepted, no dreq_valid_o. Next read of that line hits.
- Fill five lines mapping to one set: fifth fill evicts way 0. Invalidate-all return then forces all to miss.
- areq_ex_i = 1: dreq_valid_o with dreq_ex_o = 1, no mem_data_req_o.
